alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequences the shared 8-bit ALU on behalf of one command source.
- Accepts a complete operation (operand A, operand B, opcode) through a valid/ready handshake.
- Drives the ALU's shared data bus and its three one-hot load enables over three cycles, waits one settle cycle, then captures result, carry and zero.
- Returns the captured values through a valid/ready response handshake, rejects illegal opcodes without touching the ALU, and counts completed responses.

Parameters:
- NB_DATA, 8, operand/result width. The opcode field is NB_OP = NB_DATA-2 bits (local, derived); 8 is the only verified value.
- NB_CNT, 16, width of the completed-response counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready; 1 only in IDLE.
- i_cmd_a  in  NB_DATA  operand A.
- i_cmd_b  in  NB_DATA  operand B.
- i_cmd_op  in  NB_OP  opcode.
- o_alu_data  out  NB_DATA  shared ALU data bus.
- o_alu_enable_1  out  1  ALU load operand A.
- o_alu_enable_2  out  1  ALU load operand B.
- o_alu_enable_3  out  1  ALU load opcode.
- i_alu_data  in  NB_DATA  ALU result (combinational).
- i_alu_carry  in  1  ALU carry.
- i_alu_zero  in  1  ALU zero.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_data  out  NB_DATA  captured result.
- o_rsp_carry  out  1  captured carry.
- o_rsp_zero  out  1  captured zero.
- o_rsp_error  out  1  illegal opcode flag.
- o_busy  out  1  1 whenever the state is not IDLE.
- o_op_count  out  NB_CNT  completed responses; wraps.

Behaviour:
- All outputs are registered. While i_reset=0 (asynchronous): state=IDLE, every output 0 except o_cmd_ready=1, o_op_count=0.
- Command latch: accept when IDLE && i_cmd_valid (cycle T). A, B and op are latched; later changes on i_cmd_* are ignored.
- Legal opcodes (6 LSBs, upper opcode bits 0): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 100110 XOR, 000010 SRL, 000011 SRA.
- IDLE -> LOAD_A on acceptance of a legal opcode.
- IDLE -> RESP on acceptance of an illegal opcode: rsp_data=0, carry=0, zero=0, error=1, no ALU enable asserted. Latency 1: o_rsp_valid is high at T+1.
- LOAD_A (T+1): o_alu_data=A, o_alu_enable_1=1 -> LOAD_B.
- LOAD_B (T+2): o_alu_data=B, o_alu_enable_2=1 -> LOAD_OP.
- LOAD_OP (T+3): o_alu_data={op,2'b00}, o_alu_enable_3=1 -> SETTLE.
- SETTLE (T+4): enables 0. At the end of the cycle, capture i_alu_data, i_alu_carry and i_alu_zero into the rsp registers, error=0 -> RESP.
- RESP (T+5 onward): o_rsp_valid=1. Response fields are held stable until i_rsp_ready=1. On that handshake: o_rsp_valid drops next cycle, o_op_count+1 (modulo 2^NB_CNT), -> IDLE.
- Legal-op latency: command accept to o_rsp_valid = 5 cycles.
- Throughput without backpressure: one op per 6 cycles (RESP with ready=1, then IDLE accept).
- Enables are strictly one-hot-or-zero and never assert outside LOAD_A/LOAD_B/LOAD_OP.
- o_alu_data=0 in every state except the three LOAD states.
- Backpressure: RESP is held indefinitely; no new command is accepted (o_cmd_ready=0).
- Simultaneous events: o_cmd_ready is deasserted in RESP, so no same-cycle accept at the response handshake.
- Reset mid-operation: immediate return to IDLE with enables dropped. The partially loaded ALU registers are not cleared. The next command reloads all three fields, so stale ALU contents never reach a response.
- Counter wrap: all-ones + 1 -> 0, with no flag.
- Carry/zero semantics are whatever the ALU reports; the sequencer passes them through without modification.

Test Plan:
- Reset release, then ADD A=0xF0 B=0x20 op=100000 -> enables 1,2,3 pulse at T+1..T+3; o_alu_data 0xF0, 0x20, 0x80; o_rsp_valid at T+5 with data=0x10, carry=1, zero=0; o_op_count=1.
- SUB A=0x05 B=0x05 op=100010 with i_rsp_ready held 0 for 10 cycles -> data=0x00, carry=1, zero=1 held stable for all 10 cycles; o_cmd_ready=0 throughout; o_op_count increments only on the handshake.
- Illegal op=111111 -> o_rsp_valid at T+1, error=1, data=0; no enable pulses observed; counter increments.
- Reset asserted during LOAD_B -> enables drop immediately, o_busy=0, o_cmd_ready=1; a following SRL A=0x80 B=0x40 (shift 1) -> data=0x40, error=0.
- Back-to-back commands with i_cmd_valid held high and changing operands after accept -> exactly one op per 6 cycles; operands changed after accept have no effect; counter preloaded by NB_CNT=2 run of 5 ops wraps to 1.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, shared-ALU bus and response signals of alu_op_sequencer.
// Names are from the sequencer's point of view: slave = sequencer, master = command source plus ALU.
interface alu_op_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CNT  = 16
);
    localparam int NB_OP = NB_DATA - 2;

    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [NB_DATA-1:0] i_cmd_a;
    logic [NB_DATA-1:0] i_cmd_b;
    logic [NB_OP-1:0]   i_cmd_op;

    logic [NB_DATA-1:0] o_alu_data;
    logic               o_alu_enable_1;
    logic               o_alu_enable_2;
    logic               o_alu_enable_3;
    logic [NB_DATA-1:0] i_alu_data;
    logic               i_alu_carry;
    logic               i_alu_zero;

    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [NB_DATA-1:0] o_rsp_data;
    logic               o_rsp_carry;
    logic               o_rsp_zero;
    logic               o_rsp_error;

    logic               o_busy;
    logic [NB_CNT-1:0]  o_op_count;

    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        input  i_alu_data, i_alu_carry, i_alu_zero,
        input  i_rsp_ready,
        output o_cmd_ready,
        output o_alu_data, o_alu_enable_1, o_alu_enable_2, o_alu_enable_3,
        output o_rsp_valid, o_rsp_data, o_rsp_carry, o_rsp_zero, o_rsp_error,
        output o_busy, o_op_count
    );

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        output i_alu_data, i_alu_carry, i_alu_zero,
        output i_rsp_ready,
        input  o_cmd_ready,
        input  o_alu_data, o_alu_enable_1, o_alu_enable_2, o_alu_enable_3,
        input  o_rsp_valid, o_rsp_data, o_rsp_carry, o_rsp_zero, o_rsp_error,
        input  o_busy, o_op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Loads operand A, operand B and opcode into the shared ALU over one bus, waits a settle
// cycle, captures result/carry/zero and returns them through a valid/ready response.
module alu_op_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_CNT  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    alu_op_sequencer_if.slave bus
);
    localparam int NB_OP = NB_DATA - 2;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_LOAD_OP = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;

    logic               r_cmd_ready;
    logic               r_busy;
    logic [NB_DATA-1:0] r_alu_data;
    logic [2:0]         r_alu_en;
    logic               r_rsp_valid;
    logic [NB_DATA-1:0] r_rsp_data;
    logic               r_rsp_carry;
    logic               r_rsp_zero;
    logic               r_rsp_error;
    logic [NB_CNT-1:0]  r_op_count;

    logic               w_legal;
    logic               w_accept;
    logic               w_rsp_handshake;
    logic [NB_DATA-1:0] w_alu_data_next;
    logic [2:0]         w_alu_en_next;

    always_comb begin
        w_legal = 1'b0;
        case (bus.i_cmd_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_NOR, OP_XOR, OP_SRL, OP_SRA: w_legal = 1'b1;
            default:                        w_legal = 1'b0;
        endcase
    end

    assign w_accept        = (r_state == ST_IDLE) && bus.i_cmd_valid;
    assign w_rsp_handshake = (r_state == ST_RESP) && bus.i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    w_state_next = w_legal ? ST_LOAD_A : ST_RESP;
                end
            end
            ST_LOAD_A:  w_state_next = ST_LOAD_B;
            ST_LOAD_B:  w_state_next = ST_LOAD_OP;
            ST_LOAD_OP: w_state_next = ST_SETTLE;
            ST_SETTLE:  w_state_next = ST_RESP;
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Every output is a flop, so each one is decoded from the state it will be in next cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_alu_en
            assign w_alu_en_next[gi] = (w_state_next == state_t'(3'(gi + 1)));
        end
    endgenerate

    // LOAD_A is only entered straight from an accept, so operand A comes from the command port.
    always_comb begin
        w_alu_data_next = '0;
        case (w_state_next)
            ST_LOAD_A:  w_alu_data_next = bus.i_cmd_a;
            ST_LOAD_B:  w_alu_data_next = r_b;
            ST_LOAD_OP: w_alu_data_next = {r_op, 2'b00};
            default:    w_alu_data_next = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_b         <= '0;
            r_op        <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_alu_data  <= '0;
            r_alu_en    <= 3'b000;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_error <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_cmd_ready <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);
            r_rsp_valid <= (w_state_next == ST_RESP);
            r_alu_data  <= w_alu_data_next;
            r_alu_en    <= w_alu_en_next;

            if (w_accept) begin
                r_b  <= bus.i_cmd_b;
                r_op <= bus.i_cmd_op;
            end

            if (w_accept && !w_legal) begin
                r_rsp_data  <= '0;
                r_rsp_carry <= 1'b0;
                r_rsp_zero  <= 1'b0;
                r_rsp_error <= 1'b1;
            end else if (r_state == ST_SETTLE) begin
                r_rsp_data  <= bus.i_alu_data;
                r_rsp_carry <= bus.i_alu_carry;
                r_rsp_zero  <= bus.i_alu_zero;
                r_rsp_error <= 1'b0;
            end

            if (w_rsp_handshake) begin
                r_op_count <= r_op_count + NB_CNT'(1);
            end
        end
    end

    assign bus.o_cmd_ready    = r_cmd_ready;
    assign bus.o_busy         = r_busy;
    assign bus.o_alu_data     = r_alu_data;
    assign bus.o_alu_enable_1 = r_alu_en[0];
    assign bus.o_alu_enable_2 = r_alu_en[1];
    assign bus.o_alu_enable_3 = r_alu_en[2];
    assign bus.o_rsp_valid    = r_rsp_valid;
    assign bus.o_rsp_data     = r_rsp_data;
    assign bus.o_rsp_carry    = r_rsp_carry;
    assign bus.o_rsp_zero     = r_rsp_zero;
    assign bus.o_rsp_error    = r_rsp_error;
    assign bus.o_op_count     = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a 16-bit-counter instance plus a 2-bit-counter twin fed the same
// commands, each driving its own stand-in ALU built from bus-loaded registers.
module tb_alu_op_sequencer;
    localparam int NB_DATA  = 8;
    localparam int NB_CNT   = 16;
    localparam int NB_CNT_W = 2;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    logic [5:0] legal_ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SRL, OP_SRA};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer_if #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT))   bus   ();
    alu_op_sequencer_if #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT_W)) bus_w ();

    alu_op_sequencer #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    alu_op_sequencer #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT_W)) dut_w (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_w)
    );

    assign bus_w.i_cmd_valid = bus.i_cmd_valid;
    assign bus_w.i_cmd_a     = bus.i_cmd_a;
    assign bus_w.i_cmd_b     = bus.i_cmd_b;
    assign bus_w.i_cmd_op    = bus.i_cmd_op;
    assign bus_w.i_rsp_ready = bus.i_rsp_ready;

    // Reference ALU function: carry is carry-out for ADD, no-borrow for SUB, shifted-out bit for shifts.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [8:0] sum;
        logic [7:0] r;
        logic       c;
        sum = 9'd0;
        r   = 8'h00;
        c   = 1'b0;
        case (op)
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; r = sum[7:0]; c = sum[8]; end
            OP_SUB: begin r = a - b; c = (a >= b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_XOR: r = a ^ b;
            OP_SRL: begin r = a >> 1; c = a[0]; end
            OP_SRA: begin r = {a[7], a[7:1]}; c = a[0]; end
            default: ;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SRL, OP_SRA};
    endfunction

    // Stand-in ALUs: registers loaded from the shared bus, combinational result.
    logic [7:0] alu_a, alu_b, alu_opr;
    logic [7:0] alu_w_a, alu_w_b, alu_w_opr;
    always @(posedge clk) begin
        if (bus.o_alu_enable_1)   alu_a     <= bus.o_alu_data;
        if (bus.o_alu_enable_2)   alu_b     <= bus.o_alu_data;
        if (bus.o_alu_enable_3)   alu_opr   <= bus.o_alu_data;
        if (bus_w.o_alu_enable_1) alu_w_a   <= bus_w.o_alu_data;
        if (bus_w.o_alu_enable_2) alu_w_b   <= bus_w.o_alu_data;
        if (bus_w.o_alu_enable_3) alu_w_opr <= bus_w.o_alu_data;
    end
    assign {bus.i_alu_carry, bus.i_alu_zero, bus.i_alu_data}       = alu_fn(alu_a, alu_b, alu_opr[7:2]);
    assign {bus_w.i_alu_carry, bus_w.i_alu_zero, bus_w.i_alu_data} = alu_fn(alu_w_a, alu_w_b, alu_w_opr[7:2]);

    // {busy, cmd_ready, rsp_valid, enable_3, enable_2, enable_1}
    function automatic logic [5:0] ctl();
        return {bus.o_busy, bus.o_cmd_ready, bus.o_rsp_valid,
                bus.o_alu_enable_3, bus.o_alu_enable_2, bus.o_alu_enable_1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, checked cycle by cycle against the timeline the rules imply.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input int hold, input bit keep_valid, output int acc_cyc);
        bit         legal;
        logic [9:0] exp_rsp;
        logic [5:0] exp_ctl;
        logic [7:0] exp_d;
        int         lat;
        legal   = is_legal(op);
        exp_rsp = legal ? alu_fn(a, b, op) : 10'd0;
        lat     = legal ? 5 : 1;

        n_vec++;
        if ({ctl(), bus.o_alu_data} !== {6'b010000, 8'h00}) begin
            n_err++;
            $display("FAIL idle_before op=%b: ctl/data got %b/%h want 010000/00", op, ctl(), bus.o_alu_data);
        end
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_op    = op;
        bus.i_rsp_ready = 1'b0;
        acc_cyc = cyc;
        step();
        bus.i_cmd_valid = keep_valid;
        bus.i_cmd_a     = 8'($urandom);
        bus.i_cmd_b     = 8'($urandom);
        bus.i_cmd_op    = 6'($urandom);

        for (int k = 1; k < lat; k++) begin
            exp_ctl = {3'b100, (k <= 3) ? 3'(1 << (k - 1)) : 3'b000};
            exp_d   = (k == 1) ? a : (k == 2) ? b : (k == 3) ? {op, 2'b00} : 8'h00;
            n_vec++;
            if ({ctl(), bus.o_alu_data} !== {exp_ctl, exp_d}) begin
                n_err++;
                $display("FAIL load_T+%0d op=%b: ctl/data got %b/%h want %b/%h",
                         k, op, ctl(), bus.o_alu_data, exp_ctl, exp_d);
            end
            step();
        end

        for (int h = 0; h <= hold; h++) begin
            n_vec++;
            if ({ctl(), bus.o_alu_data, bus.o_rsp_error, bus.o_rsp_carry, bus.o_rsp_zero, bus.o_rsp_data}
                !== {6'b101000, 8'h00, !legal, exp_rsp[9], exp_rsp[8], exp_rsp[7:0]}) begin
                n_err++;
                $display("FAIL resp_T+%0d op=%b: ctl=%b bus=%h err/c/z/data got %b%b%b/%h want %b%b%b/%h",
                         lat + h, op, ctl(), bus.o_alu_data, bus.o_rsp_error, bus.o_rsp_carry,
                         bus.o_rsp_zero, bus.o_rsp_data, !legal, exp_rsp[9], exp_rsp[8], exp_rsp[7:0]);
            end
            n_vec++;
            if ({bus.o_op_count, bus_w.o_op_count} !== {16'(exp_cnt), 2'(exp_cnt)}) begin
                n_err++;
                $display("FAIL count_hold op=%b: got %0d/%0d want %0d/%0d",
                         op, bus.o_op_count, bus_w.o_op_count, 16'(exp_cnt), 2'(exp_cnt));
            end
            if (h == hold) bus.i_rsp_ready = 1'b1;
            step();
        end
        bus.i_rsp_ready = 1'b0;
        exp_cnt++;

        n_vec++;
        if ({ctl(), bus.o_op_count, bus_w.o_op_count} !== {6'b010000, 16'(exp_cnt), 2'(exp_cnt)}) begin
            n_err++;
            $display("FAIL after_handshake op=%b: ctl/cnt/cnt_w got %b/%0d/%0d want 010000/%0d/%0d",
                     op, ctl(), bus.o_op_count, bus_w.o_op_count, 16'(exp_cnt), 2'(exp_cnt));
        end
        $display("op=%b a=%h b=%h hold=%0d -> data=%h c=%b z=%b err=%b cnt=%0d cnt_w=%0d",
                 op, a, b, hold, exp_rsp[7:0], exp_rsp[9], exp_rsp[8], !legal,
                 bus.o_op_count, bus_w.o_op_count);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = 8'h00;
        bus.i_cmd_b     = 8'h00;
        bus.i_cmd_op    = 6'h00;
        bus.i_rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({ctl(), bus.o_alu_data, bus.o_rsp_error, bus.o_rsp_carry, bus.o_rsp_zero, bus.o_rsp_data,
             bus.o_op_count, bus_w.o_op_count} !== {6'b010000, 8'h00, 3'b000, 8'h00, 16'd0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_state: ctl=%b bus=%h err/c/z=%b%b%b data=%h cnt=%0d want ctl=010000 rest 0",
                     ctl(), bus.o_alu_data, bus.o_rsp_error, bus.o_rsp_carry, bus.o_rsp_zero,
                     bus.o_rsp_data, bus.o_op_count);
        end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (ctl() !== 6'b010000) begin
            n_err++;
            $display("FAIL reset_release: ctl got %b want 010000", ctl());
        end
        $display("reset released: ctl=%b cnt=%0d", ctl(), bus.o_op_count);
    endtask

    task automatic test_add();
        int acc;
        do_op(8'hF0, 8'h20, OP_ADD, 0, 1'b0, acc);
    endtask

    task automatic test_backpressure();
        int acc;
        do_op(8'h05, 8'h05, OP_SUB, 10, 1'b0, acc);
    endtask

    task automatic test_illegal();
        int acc;
        do_op(8'h5A, 8'hC3, 6'b111111, 2, 1'b0, acc);
        do_op(8'h12, 8'h34, 6'b100001, 0, 1'b0, acc);
    endtask

    task automatic test_reset_mid_op();
        int acc;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 8'h3C;
        bus.i_cmd_b     = 8'hA5;
        bus.i_cmd_op    = OP_XOR;
        step();
        bus.i_cmd_valid = 1'b0;
        step();
        n_vec++;
        if ({ctl(), bus.o_alu_data} !== {6'b100010, 8'hA5}) begin
            n_err++;
            $display("FAIL mid_op_load_b: ctl/data got %b/%h want 100010/a5", ctl(), bus.o_alu_data);
        end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_vec++;
        if ({ctl(), bus.o_alu_data, bus.o_op_count, bus_w.o_op_count}
            !== {6'b010000, 8'h00, 16'd0, 2'd0}) begin
            n_err++;
            $display("FAIL mid_op_reset: ctl/data/cnt got %b/%h/%0d want 010000/00/0",
                     ctl(), bus.o_alu_data, bus.o_op_count);
        end
        $display("reset during LOAD_B: ctl=%b", ctl());
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_op(8'h80, 8'h40, OP_SRL, 0, 1'b0, acc);
    endtask

    task automatic test_random();
        int         acc;
        logic [5:0] op;
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
            do_op(8'($urandom), 8'($urandom), op, $urandom_range(0, 3), 1'b0, acc);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int prev;
        prev = 0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(8'($urandom), 8'($urandom), legal_ops[$urandom_range(0, 7)], 0, (i < 4), acc);
            if (i > 0) begin
                n_vec++;
                if (acc - prev !== 6) begin
                    n_err++;
                    $display("FAIL b2b_period op#%0d: got %0d cycles want 6", i, acc - prev);
                end
            end
            prev = acc;
        end
        bus.i_cmd_valid = 1'b0;
        n_vec++;
        if ({bus.o_op_count, bus_w.o_op_count} !== {16'd5, 2'd1}) begin
            n_err++;
            $display("FAIL counter_wrap: got %0d/%0d want 5/1", bus.o_op_count, bus_w.o_op_count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
